bus_mem_ctrl: RTL and testbench
===============================

# bus_mem_ctrl

Bus-side memory controller that sits directly downstream of the CPU's external bus port. It consumes single transactions (`bus_addr`, `bus_data`, `bus_we`, `bus_start`) and returns `bus_q` and `bus_done`. It decodes the 27-bit word address into SDRAM, internal ROM, IO and unmapped regions, and runs the matching downstream handshake. A sticky error flag records unmapped accesses, ROM writes and (optionally) timeouts.

## Interface
- `ROM_AW`, 10: ROM word-address width.
- `TIMEOUT_CYCLES`, 1024: maximum number of wait cycles for SDRAM/IO when the timeout is compiled in.
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `bus_addr` in 27: word address.
- `bus_data` in 32: write data.
- `bus_we` in 1: 1 = write.
- `bus_start` in 1: request, sampled in IDLE only.
- `bus_q` out 32: read data, registered.
- `bus_done` out 1: one-cycle completion pulse, registered.
- `sd_addr` out 26, `sd_data` out 32, `sd_we` out 1, `sd_req` out 1: SDRAM request (level).
- `sd_q` in 32, `sd_ack` in 1: SDRAM response (one-cycle pulse).
- `rom_addr` out ROM_AW: synchronous ROM address.
- `rom_q` in 32: ROM read data, 1-cycle latency.
- `io_addr` out 8, `io_data` out 32, `io_we` out 1, `io_start` out 1: IO request (pulse).
- `io_q` in 32, `io_done` in 1: IO response.
- `err_clr` in 1: clears `err`.
- `err` out 1: sticky error flag.

## Operation
- Address map on `bus_addr[26:24]`:
  - `0xx`: SDRAM, `sd_addr = bus_addr[25:0]`.
  - `100`: ROM, `rom_addr = bus_addr[ROM_AW-1:0]`.
  - `101`: IO, `io_addr = bus_addr[7:0]`.
  - `11x`: unmapped.
- On `bus_start` in IDLE, address, data and we are latched. All downstream address/data/we outputs come from these latches and stay stable until completion.
- States: IDLE, SD_WAIT, ROM_RD, ROM_OUT, IO_WAIT, RESP.
  - IDLE + start → SD_WAIT / ROM_RD / IO_WAIT by region. ROM write and unmapped go to RESP.
  - SD_WAIT: `sd_req`=1 until `sd_ack` is sampled. Then `bus_q`<=`sd_q` (reads; 0 for writes), `bus_done`<=1, → IDLE.
  - ROM_RD → ROM_OUT. In ROM_OUT: `bus_q`<=`rom_q`, done, → IDLE.
  - IO_WAIT: `io_start`=1 on the first cycle only. On `io_done`: `bus_q`<=`io_q` (0 for writes), done, → IDLE.
  - RESP: `bus_q`<=0, done, `err` set, → IDLE.
- `bus_start` outside IDLE is ignored; the master must wait for `bus_done`.
- `sd_ack`/`io_done` arriving outside their wait state are ignored.
- `err`: set on unmapped access, ROM write or timeout; cleared by `err_clr`. Set wins over a simultaneous clear.

## Timing
- Reset values: state IDLE; `bus_q`=0, `bus_done`=0, `sd_req`=0, `io_start`=0, `err`=0; latched addr/data/we = 0.
- Latency, counting the start cycle as cycle 0:
  - ROM read: `bus_done` in cycle 3.
  - Unmapped or ROM write: `bus_done` in cycle 2.
  - SDRAM/IO: `bus_done` in the cycle after the ack; earliest is cycle 2, when the ack arrives in cycle 1.
- Back-to-back: the `bus_done` cycle is already IDLE, so a `bus_start` in that cycle is accepted.
- `sd_req` deasserts in the cycle after `sd_ack` is sampled.
- Reset mid-transaction: the transaction is abandoned with no `bus_done`, and `sd_req` drops asynchronously.

## Configuration
- `MEM_BUS_TIMEOUT_EN` defined:
  - A wait counter (width `$clog2(TIMEOUT_CYCLES)+1`) clears on entering SD_WAIT/IO_WAIT and increments each cycle without an ack.
  - When it reaches `TIMEOUT_CYCLES`: `sd_req` drops, `bus_q`<=0, `bus_done`<=1, `err` set, → IDLE.
  - An ack in the same cycle as the limit wins, and the transfer completes normally.
- `MEM_BUS_TIMEOUT_EN` undefined: no counter; SD_WAIT/IO_WAIT wait indefinitely.

## Test plan
- ROM read, `bus_addr`=0x4000005, `rom_q`=0x12345678 → `rom_addr`=5, `bus_done` in cycle 3 with `bus_q`=0x12345678, `err`=0.
- SDRAM write, addr 0x0000010, data 0xCAFEBABE, `sd_ack` in cycle 4 → `sd_req`=1 in cycles 1-4, `sd_we`=1, `sd_data`=0xCAFEBABE, `bus_done` in cycle 5, `bus_q`=0.
- Unmapped read 0x6000000, then ROM write 0x4000001 → each done 2 cycles after start with `bus_q`=0; `err`=1. Then `err_clr` → 0; `err_clr` coinciding with a new unmapped access → `err` stays 1.
- IO read, addr 0x5000003, `io_done` in cycle 1 with `io_q`=0xA5 → `io_start` pulse in cycle 1 only, done in cycle 2. A second start in the done cycle is accepted.
- With `MEM_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no `sd_ack` → done with `bus_q`=0 after 8 wait cycles, `err`=1. A late `sd_ack` is ignored.
- Reset asserted in SD_WAIT → `sd_req`=0 immediately, no `bus_done`. The next ROM read after release completes normally.

Source files
------------

// File: rtl/bus_mem_ctrl.sv
// ---------------------------------------------------------------------------
// bus_mem_ctrl
//
// Bus-side memory controller placed directly downstream of the CPU external
// bus port. It accepts one transaction at a time, decodes the 27-bit word
// address into SDRAM / internal ROM / IO / unmapped regions, runs the matching
// downstream handshake and returns a registered read word plus a one-cycle
// completion pulse. A sticky error flag records unmapped accesses, ROM writes
// and, when compiled in, wait timeouts.
//
// Address map (bus_addr[26:24]):
//   0xx  SDRAM     sd_addr  = bus_addr[25:0]
//   100  ROM       rom_addr = bus_addr[ROM_AW-1:0]  (reads only)
//   101  IO        io_addr  = bus_addr[7:0]
//   11x  unmapped
//
// Optional feature macro: MEM_BUS_TIMEOUT_EN
//   Defined   : SD_WAIT / IO_WAIT give up after TIMEOUT_CYCLES cycles without
//               an acknowledge, complete with bus_q = 0 and set err.
//   Undefined : SD_WAIT / IO_WAIT wait indefinitely.
//
// Parameters:
//   ROM_AW          ROM word-address width (must not exceed 26)
//   TIMEOUT_CYCLES  wait-cycle limit used when MEM_BUS_TIMEOUT_EN is defined
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   bus_addr/data/we/start     CPU request (start sampled in IDLE only)
//   bus_q, bus_done            registered read data, one-cycle done pulse
//   sd_addr/data/we/req        SDRAM request (req is a level)
//   sd_q, sd_ack               SDRAM response (ack is a one-cycle pulse)
//   rom_addr, rom_q            synchronous ROM, one-cycle read latency
//   io_addr/data/we/start      IO request (start is a one-cycle pulse)
//   io_q, io_done              IO response
//   err_clr, err               sticky error flag and its clear
// ---------------------------------------------------------------------------
module bus_mem_ctrl #(
  parameter int ROM_AW         = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [26:0]       bus_addr,
  input  logic [31:0]       bus_data,
  input  logic              bus_we,
  input  logic              bus_start,
  output logic [31:0]       bus_q,
  output logic              bus_done,
  output logic [25:0]       sd_addr,
  output logic [31:0]       sd_data,
  output logic              sd_we,
  output logic              sd_req,
  input  logic [31:0]       sd_q,
  input  logic              sd_ack,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_q,
  output logic [7:0]        io_addr,
  output logic [31:0]       io_data,
  output logic              io_we,
  output logic              io_start,
  input  logic [31:0]       io_q,
  input  logic              io_done,
  input  logic              err_clr,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SD_WAIT,
    ST_ROM_RD,
    ST_ROM_OUT,
    ST_IO_WAIT,
    ST_RESP
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  // Request latches; bit 26 only matters for decoding, which happens in IDLE
  // straight from bus_addr, so it is not kept.
  logic [25:0] r_addr;
  logic [31:0] r_data;
  logic        r_we;

  logic [31:0] r_busQ;
  logic        r_busDone;
  logic        r_ioStart;
  logic        r_err;

  logic        w_accept;
  logic        w_doneNext;
  logic [31:0] w_qNext;
  logic        w_errSet;
  logic        w_ioStartNext;
  logic        w_timeout;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] r_waitCnt;
  logic             w_inWait;
  logic             w_waitAck;

  assign w_inWait  = (r_state == ST_SD_WAIT) || (r_state == ST_IO_WAIT);
  assign w_waitAck = ((r_state == ST_SD_WAIT) && sd_ack) ||
                     ((r_state == ST_IO_WAIT) && io_done);

  // Wait counter: cleared when a transaction is accepted, counts every
  // ack-less wait cycle. The counter value is the number of wait cycles
  // already spent, so the limit is hit in the cycle whose increment would
  // make it TIMEOUT_CYCLES. An ack in that same cycle takes priority in the
  // FSM, so the transfer then completes normally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waitCnt <= '0;
    end else if (w_accept) begin
      r_waitCnt <= '0;
    end else if (w_inWait && !w_waitAck) begin
      r_waitCnt <= r_waitCnt + CNT_W'(1);
    end
  end

  assign w_timeout = w_inWait && !w_waitAck &&
                     (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and completion decode. bus_q only changes on completion, so
  // the default holds its current value.
  always_comb begin
    w_nextState   = r_state;
    w_accept      = 1'b0;
    w_doneNext    = 1'b0;
    w_qNext       = r_busQ;
    w_errSet      = 1'b0;
    w_ioStartNext = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus_start) begin
          w_accept = 1'b1;
          casez (bus_addr[26:24])
            3'b0??: w_nextState = ST_SD_WAIT;
            3'b100: w_nextState = bus_we ? ST_RESP : ST_ROM_RD;
            3'b101: begin
              w_nextState   = ST_IO_WAIT;
              w_ioStartNext = 1'b1;
            end
            default: w_nextState = ST_RESP;
          endcase
        end
      end

      ST_SD_WAIT: begin
        if (sd_ack) begin
          w_doneNext  = 1'b1;
          w_qNext     = r_we ? 32'h0 : sd_q;
          w_nextState = ST_IDLE;
        end else if (w_timeout) begin
          w_doneNext  = 1'b1;
          w_qNext     = 32'h0;
          w_errSet    = 1'b1;
          w_nextState = ST_IDLE;
        end
      end

      // The ROM samples rom_addr at the end of this cycle; its data is valid
      // during ROM_OUT.
      ST_ROM_RD: begin
        w_nextState = ST_ROM_OUT;
      end

      ST_ROM_OUT: begin
        w_doneNext  = 1'b1;
        w_qNext     = rom_q;
        w_nextState = ST_IDLE;
      end

      ST_IO_WAIT: begin
        if (io_done) begin
          w_doneNext  = 1'b1;
          w_qNext     = r_we ? 32'h0 : io_q;
          w_nextState = ST_IDLE;
        end else if (w_timeout) begin
          w_doneNext  = 1'b1;
          w_qNext     = 32'h0;
          w_errSet    = 1'b1;
          w_nextState = ST_IDLE;
        end
      end

      ST_RESP: begin
        w_doneNext  = 1'b1;
        w_qNext     = 32'h0;
        w_errSet    = 1'b1;
        w_nextState = ST_IDLE;
      end

      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Request latches: every downstream address/data/we is driven from these,
  // so they stay stable while the master changes bus_* mid-transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_data <= '0;
      r_we   <= 1'b0;
    end else if (w_accept) begin
      r_addr <= bus_addr[25:0];
      r_data <= bus_data;
      r_we   <= bus_we;
    end
  end

  // Registered bus response and the one-cycle IO start pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busQ    <= '0;
      r_busDone <= 1'b0;
      r_ioStart <= 1'b0;
    end else begin
      r_busQ    <= w_qNext;
      r_busDone <= w_doneNext;
      r_ioStart <= w_ioStartNext;
    end
  end

  // Sticky error flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_errSet) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign bus_q    = r_busQ;
  assign bus_done = r_busDone;

  // Decoded from the state register so that an asynchronous reset drops the
  // request immediately.
  assign sd_req   = (r_state == ST_SD_WAIT);
  assign sd_addr  = r_addr;
  assign sd_data  = r_data;
  assign sd_we    = r_we;

  assign rom_addr = r_addr[ROM_AW-1:0];

  assign io_addr  = r_addr[7:0];
  assign io_data  = r_data;
  assign io_we    = r_we;
  assign io_start = r_ioStart;

  assign err      = r_err;

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_mem_ctrl
//
// Self-checking bench for bus_mem_ctrl. The bench plays the CPU master, the
// SDRAM, the synchronous ROM and the IO device. For each transaction it
// works out from the address map and the latency rules what the outputs
// must look like cycle by cycle (done cycle, read word, request levels,
// error flag) and a single compare process checks the DUT on every falling
// edge. A few directed transactions use hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_bus_mem_ctrl;

  localparam int ROM_AW = 10;
  localparam int TC     = 8;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic [26:0]       bus_addr  = '0;
  logic [31:0]       bus_data  = '0;
  logic              bus_we    = 1'b0;
  logic              bus_start = 1'b0;
  logic [31:0]       bus_q;
  logic              bus_done;
  logic [25:0]       sd_addr;
  logic [31:0]       sd_data;
  logic              sd_we;
  logic              sd_req;
  logic [31:0]       sd_q      = '0;
  logic              sd_ack    = 1'b0;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_q     = '0;
  logic [7:0]        io_addr;
  logic [31:0]       io_data;
  logic              io_we;
  logic              io_start;
  logic [31:0]       io_q      = '0;
  logic              io_done   = 1'b0;
  logic              err_clr   = 1'b0;
  logic              err;

  bus_mem_ctrl #(
    .ROM_AW         (ROM_AW),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .bus_we    (bus_we),
    .bus_start (bus_start),
    .bus_q     (bus_q),
    .bus_done  (bus_done),
    .sd_addr   (sd_addr),
    .sd_data   (sd_data),
    .sd_we     (sd_we),
    .sd_req    (sd_req),
    .sd_q      (sd_q),
    .sd_ack    (sd_ack),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .io_addr   (io_addr),
    .io_data   (io_data),
    .io_we     (io_we),
    .io_start  (io_start),
    .io_q      (io_q),
    .io_done   (io_done),
    .err_clr   (err_clr),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Expected values for the current cycle, consumed by the compare process.
  logic        eDone   = 1'b0;
  logic [31:0] eQ      = '0;
  logic        eErr    = 1'b0;
  logic        eSdReq  = 1'b0;
  logic        eIoStart = 1'b0;
  logic        eRomChk = 1'b0;
  logic        qChk    = 1'b1;
  logic [25:0] eAddr   = '0;
  logic [31:0] eData   = '0;
  logic        eWe     = 1'b0;

  int checks   = 0;
  int failures = 0;

  // ROM contents: word 5 holds a fixed literal, the rest is a hash.
  function automatic logic [31:0] romWord(input logic [ROM_AW-1:0] ra);
    if (ra == ROM_AW'(5)) return 32'h12345678;
    return (32'h9E3779B9 * 32'(ra)) ^ (32'(ra) << 22);
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) rom_q <= romWord(rom_addr);

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Single compare process, sampling away from the rising edge.
  always @(negedge clk) begin
    checkOutput("bus_done", 32'(bus_done), 32'(eDone));
    if (eDone || qChk) checkOutput("bus_q", bus_q, eQ);
    checkOutput("err", 32'(err), 32'(eErr));
    checkOutput("sd_req", 32'(sd_req), 32'(eSdReq));
    checkOutput("io_start", 32'(io_start), 32'(eIoStart));
    if (eSdReq) begin
      checkOutput("sd_addr", 32'(sd_addr), 32'(eAddr));
      checkOutput("sd_data", sd_data, eData);
      checkOutput("sd_we", 32'(sd_we), 32'(eWe));
    end
    if (eIoStart) begin
      checkOutput("io_addr", 32'(io_addr), 32'(eAddr[7:0]));
      checkOutput("io_data", io_data, eData);
      checkOutput("io_we", 32'(io_we), 32'(eWe));
    end
    if (eRomChk) checkOutput("rom_addr", 32'(rom_addr), 32'(eAddr[ROM_AW-1:0]));
  end

  // Advance to just after the next rising edge and return all pulse-type
  // stimulus and per-cycle expectations to their quiet values.
  task automatic step();
    @(posedge clk);
    #1;
    eDone     = 1'b0;
    eSdReq    = 1'b0;
    eIoStart  = 1'b0;
    eRomChk   = 1'b0;
    bus_start = 1'b0;
    sd_ack    = 1'b0;
    io_done   = 1'b0;
    err_clr   = 1'b0;
    sd_q      = $urandom;
    io_q      = $urandom;
  endtask

  // Idle cycles with stray acknowledges and bus noise that must be ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      bus_addr = 27'($urandom);
      bus_data = $urandom;
      bus_we   = 1'($urandom);
      sd_ack   = 1'($urandom);
      io_done  = 1'($urandom);
    end
  endtask

  task automatic clearErr();
    err_clr = 1'b1;
    step();
    eErr = 1'b0;
  endtask

  // One transaction starting in the current cycle (cycle 0). lat is the
  // cycle in which the SDRAM/IO responder acknowledges. Returns positioned
  // in the done cycle, so a following call starts back-to-back.
  task automatic applyStimulus(input logic [26:0] a, input logic [31:0] d,
                               input logic w, input int lat,
                               input logic [31:0] rq, input bit clrAtSet,
                               input bit useLit, input logic [31:0] litQ,
                               input int litD);
    logic [2:0]  region;
    bit          isRom, isResp, isSd, errSet;
    int          dn;
    logic [31:0] q;
`ifdef MEM_BUS_TIMEOUT_EN
    bit          timedOut;
    timedOut = 1'b0;
`endif
    region = a[26:24];
    isSd   = (region[2] == 1'b0);
    isRom  = (region == 3'b100);
    isResp = (region[2:1] == 2'b11) || (isRom && w);
    errSet = 1'b0;
    if (isResp) begin
      dn = 2; q = 32'h0; errSet = 1'b1;
    end else if (isRom) begin
      dn = 3; q = romWord(a[ROM_AW-1:0]);
    end else begin
      dn = lat + 1; q = w ? 32'h0 : rq;
`ifdef MEM_BUS_TIMEOUT_EN
      if (lat > TC) begin
        dn = TC + 1; q = 32'h0; errSet = 1'b1; timedOut = 1'b1;
      end
`endif
    end
    if (useLit) begin
      q  = litQ;
      dn = litD;
    end

    bus_start = 1'b1;
    bus_addr  = a;
    bus_data  = d;
    bus_we    = w;
    eAddr     = a[25:0];
    eData     = d;
    eWe       = w;

    for (int c = 1; c <= dn; c++) begin
      step();
      if (c < dn) begin
        bus_start = 1'($urandom);
        bus_addr  = 27'($urandom);
        bus_data  = $urandom;
        bus_we    = 1'($urandom);
      end
      if (isResp || isRom) begin
        eRomChk = isRom && !isResp && (c == 1);
        sd_ack  = 1'($urandom);
        io_done = 1'($urandom);
      end else if (isSd) begin
        eSdReq  = (c < dn);
        io_done = 1'($urandom);
        if (c == lat) begin
          sd_ack = 1'b1;
          sd_q   = rq;
        end
      end else begin
        eIoStart = (c == 1);
        sd_ack   = 1'($urandom);
        if (c == lat) begin
          io_done = 1'b1;
          io_q    = rq;
        end
      end
      if (clrAtSet && c == dn - 1) err_clr = 1'b1;
      if (c == dn) begin
        eDone = 1'b1;
        eQ    = q;
        if (errSet) eErr = 1'b1;
        else if (clrAtSet) eErr = 1'b0;
      end
    end
`ifdef MEM_BUS_TIMEOUT_EN
    if (timedOut) begin
      step();
      if (isSd) sd_ack = 1'b1;
      else io_done = 1'b1;
      step();
    end
`endif
  endtask

  initial begin
    logic [2:0] region;
    step();
    step();
    reset = 1'b0;
    qChk  = 1'b0;
    step();

    // ROM read: rom_addr 5, done in cycle 3 with the literal ROM word.
    applyStimulus(27'h4000005, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1'b1, 32'h12345678, 3);
    idle(2);
    // SDRAM write acknowledged in cycle 4: done in cycle 5, bus_q 0.
    applyStimulus(27'h0000010, 32'hCAFEBABE, 1'b1, 4, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 5);
    idle(1);
    // Unmapped read, then ROM write: done in cycle 2, bus_q 0, err set.
    applyStimulus(27'h6000000, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1'b1, 32'h0, 2);
    idle(1);
    applyStimulus(27'h4000001, 32'h55, 1'b1, 1, 32'h0, 1'b0, 1'b1, 32'h0, 2);
    idle(1);
    clearErr();
    idle(1);
    // Clear coinciding with a new error: the set wins.
    applyStimulus(27'h7000000, 32'h0, 1'b0, 1, 32'h0, 1'b1, 1'b1, 32'h0, 2);
    idle(1);
    clearErr();
    // IO read acknowledged in cycle 1, then a ROM read started in its done cycle.
    applyStimulus(27'h5000003, 32'h0, 1'b0, 1, 32'h000000A5, 1'b0, 1'b1, 32'hA5, 2);
    applyStimulus(27'h4000002, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    idle(1);
`ifdef MEM_BUS_TIMEOUT_EN
    // No ack: gives up after TC wait cycles; the late ack is ignored.
    applyStimulus(27'h0000020, 32'h0, 1'b0, 20, 32'h1, 1'b0, 1'b1, 32'h0, TC + 1);
    clearErr();
`endif

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 5: region = {1'b0, 2'($urandom)};
        2:       region = 3'b100;
        3:       region = 3'b101;
        default: region = {2'b11, 1'($urandom)};
      endcase
      applyStimulus({region, 24'($urandom)}, $urandom, 1'($urandom),
                    $urandom_range(1, 12), $urandom,
                    ($urandom_range(0, 3) == 0), 1'b0, 32'h0, 0);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) clearErr();
    end
    idle(2);

    // Force err high so the reset below also shows it clearing.
    applyStimulus(27'h6000001, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    idle(1);

    // Reset in the middle of an SDRAM wait: sd_req drops at once, no done.
    bus_start = 1'b1;
    bus_addr  = 27'h0123456;
    bus_data  = 32'h11112222;
    bus_we    = 1'b0;
    eAddr     = 26'h0123456;
    eData     = 32'h11112222;
    eWe       = 1'b0;
    step();
    eSdReq = 1'b1;
    step();
    eSdReq = 1'b1;
    #2;
    reset  = 1'b1;
    eSdReq = 1'b0;
    eErr   = 1'b0;
    eQ     = 32'h0;
    qChk   = 1'b1;
    step();
    step();
    reset = 1'b0;
    qChk  = 1'b0;
    step();
    applyStimulus(27'h4000005, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1'b1, 32'h12345678, 3);
    idle(2);

    #6;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
